// File: rtl/fp32_pkg.sv
// rtl/fp32_pkg.sv - FP32 field widths, constants, accumulator FSM encoding and pack/unpack helpers.
package fp32_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int BIAS  = 127;

  localparam logic [31:0] QNAN = 32'h7FC00000;
  localparam logic [31:0] ZERO = 32'h00000000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ALIGN,
    ST_ADD,
    ST_NORM,
    ST_OUT
  } state_t;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } fp32_t;

  function automatic fp32_t fp32_unpack(input logic [31:0] v);
    return fp32_t'(v);
  endfunction

  function automatic logic [31:0] fp32_pack(input logic s, input logic [EXP_W-1:0] e,
                                            input logic [MAN_W-1:0] m);
    return {s, e, m};
  endfunction

endpackage

// File: rtl/fp32_lzc28.sv
// rtl/fp32_lzc28.sv - combinational 28-bit leading-zero counter (all-zero input gives 28).
module fp32_lzc28 (
  input  logic [27:0] value,
  output logic [4:0]  count
);

  // Scanning upward lets the highest set bit win the final assignment.
  always_comb begin
    count = 5'd28;
    for (int i = 0; i < 28; i++) begin
      if (value[i]) count = 5'(27 - i);
    end
  end

endmodule

// File: rtl/fp32_accumulator.sv
// rtl/fp32_accumulator.sv - multi-cycle FP32 running-sum accumulator; FP32_ACC_RNE_EN enables RNE rounding.
module fp32_accumulator
  import fp32_pkg::*;
#(
  parameter int          ADD_CYCLES = 3,
  parameter logic [31:0] ACC_INIT   = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        busy
);

  generate
    if (ADD_CYCLES != 3) begin : g_bad_add_cycles
      $error("fp32_accumulator: ADD_CYCLES must be 3");
    end
  endgenerate

  state_t      state_q, state_d;
  logic [31:0] op_q, op_d, acc_q, acc_d, spec_val_q, spec_val_d;
  logic        last_q, last_d, sign_q, sign_d, sub_q, sub_d, spec_q, spec_d;
  logic [7:0]  exp_q, exp_d;
  logic [26:0] big_q, big_d, small_q, small_d;
  logic [27:0] sum_q, sum_d;

  fp32_t       a, b, big, sml;
  logic [30:0] a_mag, b_mag;
  logic [23:0] big_sig, sml_sig;
  logic [7:0]  diff;
  logic [26:0] ext, shifted, mask, small_al;
  logic        sticky, a_nan, b_nan, a_inf, b_inf;
  logic [31:0] special_val;

  always_comb begin
    a       = fp32_unpack(acc_q);
    b       = fp32_unpack(op_q);
    // Subnormals collapse to zero before the magnitude compare.
    a_mag   = (a.exp == 8'd0) ? 31'd0 : {a.exp, a.man};
    b_mag   = (b.exp == 8'd0) ? 31'd0 : {b.exp, b.man};
    big     = (b_mag > a_mag) ? b : a;
    sml     = (b_mag > a_mag) ? a : b;
    big_sig = (big.exp == 8'd0) ? 24'd0 : {1'b1, big.man};
    sml_sig = (sml.exp == 8'd0) ? 24'd0 : {1'b1, sml.man};
    diff    = big.exp - sml.exp;
    ext     = {sml_sig, 3'b000};
    shifted = 27'd0;
    mask    = 27'd0;
    sticky  = 1'b0;
    if (diff >= 8'd27) begin
      sticky = |sml_sig;
    end else begin
      shifted = ext >> diff;
      mask    = (27'd1 << diff) - 27'd1;
      sticky  = |(ext & mask);
    end
    small_al = {shifted[26:1], shifted[0] | sticky};

    a_nan = (a.exp == 8'hFF) && (a.man != 23'd0);
    b_nan = (b.exp == 8'hFF) && (b.man != 23'd0);
    a_inf = (a.exp == 8'hFF) && (a.man == 23'd0);
    b_inf = (b.exp == 8'hFF) && (b.man == 23'd0);
    if (a_nan)                                special_val = acc_q;
    else if (b_nan)                           special_val = op_q;
    else if (a_inf && b_inf && (a.sign != b.sign)) special_val = QNAN;
    else if (a_inf)                           special_val = acc_q;
    else                                      special_val = op_q;
  end

  logic [4:0]  lz, shl;
  logic [27:0] sh;
  logic [26:0] norm;
  logic [9:0]  exp_n, exp_f;
  logic [22:0] man_f;
  logic        ovf, unf, unused_norm;
  logic [31:0] norm_res;
`ifdef FP32_ACC_RNE_EN
  logic        round_up;
  logic [23:0] man_r;
`endif

  fp32_lzc28 u_lzc (
    .value (sum_q),
    .count (lz)
  );

  always_comb begin
    shl = lz - 5'd1;
    sh  = sum_q << shl;
    if (sum_q[27]) begin
      norm  = {sum_q[27:2], sum_q[1] | sum_q[0]};
      exp_n = {2'b00, exp_q} + 10'd1;
    end else begin
      norm  = sh[26:0];
      exp_n = {2'b00, exp_q} - {5'd0, shl};
    end
`ifdef FP32_ACC_RNE_EN
    round_up    = norm[2] & (norm[1] | norm[0] | norm[3]);
    man_r       = {1'b0, norm[25:3]} + {23'd0, round_up};
    man_f       = man_r[22:0];
    exp_f       = exp_n + {9'd0, man_r[23]};
    unused_norm = ^{sh[27], norm[26]};
`else
    man_f       = norm[25:3];
    exp_f       = exp_n;
    unused_norm = ^{sh[27], norm[26], norm[2:0]};
`endif
    // exp_f is two's complement in 10 bits; bit 9 set means it went negative.
    unf = exp_f[9] || (exp_f == 10'd0);
    ovf = !exp_f[9] && (exp_f >= 10'd255);
    if (spec_q)              norm_res = spec_val_q;
    else if (sum_q == 28'd0) norm_res = ZERO;
    else if (unf)            norm_res = {sign_q, 31'd0};
    else if (ovf)            norm_res = {sign_q, 8'hFF, 23'd0};
    else                     norm_res = fp32_pack(sign_q, exp_f[7:0], man_f);
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    last_d     = last_q;
    acc_d      = acc_q;
    sign_d     = sign_q;
    exp_d      = exp_q;
    sub_d      = sub_q;
    big_d      = big_q;
    small_d    = small_q;
    sum_d      = sum_q;
    spec_d     = spec_q;
    spec_val_d = spec_val_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          op_d    = in_data;
          last_d  = in_last;
          state_d = ST_ALIGN;
        end
      end
      ST_ALIGN: begin
        sign_d     = big.sign;
        exp_d      = big.exp;
        sub_d      = big.sign ^ sml.sign;
        big_d      = {big_sig, 3'b000};
        small_d    = small_al;
        spec_d     = (a.exp == 8'hFF) || (b.exp == 8'hFF);
        spec_val_d = special_val;
        state_d    = ST_ADD;
      end
      ST_ADD: begin
        sum_d   = sub_q ? ({1'b0, big_q} - {1'b0, small_q}) : ({1'b0, big_q} + {1'b0, small_q});
        state_d = ST_NORM;
      end
      ST_NORM: begin
        acc_d   = norm_res;
        state_d = last_q ? ST_OUT : ST_IDLE;
      end
      ST_OUT: begin
        if (out_ready) begin
          acc_d   = ACC_INIT;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      op_q       <= 32'd0;
      last_q     <= 1'b0;
      acc_q      <= ACC_INIT;
      sign_q     <= 1'b0;
      exp_q      <= 8'd0;
      sub_q      <= 1'b0;
      big_q      <= 27'd0;
      small_q    <= 27'd0;
      sum_q      <= 28'd0;
      spec_q     <= 1'b0;
      spec_val_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      last_q     <= last_d;
      acc_q      <= acc_d;
      sign_q     <= sign_d;
      exp_q      <= exp_d;
      sub_q      <= sub_d;
      big_q      <= big_d;
      small_q    <= small_d;
      sum_q      <= sum_d;
      spec_q     <= spec_d;
      spec_val_q <= spec_val_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_OUT);
  assign busy      = (state_q != ST_IDLE);
  assign out_data  = out_valid ? acc_q : ZERO;

endmodule

// File: tb/tb_fp32_accumulator.sv
// tb/tb_fp32_accumulator.sv - self-checking bench for fp32_accumulator (vector table plus scoreboard).
module tb_fp32_accumulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        busy;

  always #5 clk = ~clk;

  fp32_accumulator dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

`ifdef FP32_ACC_RNE_EN
  localparam logic [31:0] RND_EXP = 32'h3F800002;
`else
  localparam logic [31:0] RND_EXP = 32'h3F800001;
`endif

  typedef struct {
    string            name;
    int               n;
    logic [3:0][31:0] ops;
    logic [31:0]      exp;
  } vec_t;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] sb[$];
  vec_t        vecs[13];

  function automatic vec_t mk(string name, int n, logic [31:0] o0, logic [31:0] o1,
                              logic [31:0] o2, logic [31:0] e);
    vec_t v;
    v.name   = name;
    v.n      = n;
    v.ops[0] = o0;
    v.ops[1] = o1;
    v.ops[2] = o2;
    v.ops[3] = 32'd0;
    v.exp    = e;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result actual=%h expected=none", out_data);
      end else begin
        chk("result", out_data, sb.pop_front());
      end
    end
  end

  task automatic send_op(input logic [31:0] data, input logic last);
    int t = 0;
    while (!in_ready && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (!in_ready) chk("in_ready_timeout", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_data  = data;
    in_last  = last;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    while ((busy || out_valid) && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (busy || out_valid) chk("done_timeout", {31'd0, busy}, 32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    for (int j = 0; j < v.n; j++) begin
      if (j == v.n - 1) sb.push_back(v.exp);
      send_op(v.ops[j], (j == v.n - 1));
    end
    wait_done();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int seen;

    vecs[0]  = mk("single",       1, 32'h41C30000, 32'h0,        32'h0,        32'h41C30000);
    vecs[1]  = mk("two_sum",      2, 32'h41C30000, 32'h3F800000, 32'h0,        32'h41CB0000);
    vecs[2]  = mk("cancel",       2, 32'h40000000, 32'hC0000000, 32'h0,        32'h00000000);
    vecs[3]  = mk("after_cancel", 1, 32'h3F800000, 32'h0,        32'h0,        32'h3F800000);
    vecs[4]  = mk("tie_even",     2, 32'h3F800000, 32'h33800000, 32'h0,        32'h3F800000);
    vecs[5]  = mk("round",        2, 32'h3F800001, 32'h33C00000, 32'h0,        RND_EXP);
    vecs[6]  = mk("inf_m_inf",    2, 32'h7F800000, 32'hFF800000, 32'h0,        32'h7FC00000);
    vecs[7]  = mk("three_ones",   3, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h40400000);
    vecs[8]  = mk("subnormal",    1, 32'h00000001, 32'h0,        32'h0,        32'h00000000);
    vecs[9]  = mk("overflow",     2, 32'h7F000000, 32'h7F000000, 32'h0,        32'h7F800000);
    vecs[10] = mk("neg_sum",      2, 32'hC0400000, 32'h3F800000, 32'h0,        32'hC0000000);
    vecs[11] = mk("inf_sticky",   2, 32'h7F800000, 32'h3F800000, 32'h0,        32'h7F800000);
    vecs[12] = mk("nan_prop",     2, 32'h3F800000, 32'h7FC00001, 32'h0,        32'h7FC00001);

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 32'd0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    #12;
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data",  out_data,           32'd0);
    chk("rst_busy",      {31'd0, busy},      32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Latency of a single last operand, with in_ready held low until the handshake.
    sb.push_back(32'h41C30000);
    send_op(32'h41C30000, 1'b1);
    cyc = 1;
    while (!out_valid && cyc < 20) begin
      chk("in_ready_while_busy", {31'd0, in_ready}, 32'd0);
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("out_valid_latency", cyc, 32'd4);
    chk("in_ready_in_out", {31'd0, in_ready}, 32'd0);
    wait_done();

    foreach (vecs[i]) run_vec(vecs[i]);

    // Backpressure: five stalled cycles in OUT, handshake on the sixth.
    out_ready = 1'b0;
    send_op(32'h3F800000, 1'b0);
    sb.push_back(32'h40400000);
    send_op(32'h40000000, 1'b1);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    for (int k = 0; k < 5; k++) begin
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_out_data",  out_data,           32'h40400000);
      chk("bp_in_ready",  {31'd0, in_ready},  32'd0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_after_out_valid", {31'd0, out_valid}, 32'd0);
    chk("bp_after_in_ready",  {31'd0, in_ready},  32'd1);
    chk("bp_after_busy",      {31'd0, busy},      32'd0);
    run_vec(mk("bp_acc_reset", 1, 32'h3F800000, 32'h0, 32'h0, 32'h3F800000));

    // Reset asserted while the adder is in ADD discards the partial sum.
    send_op(32'h3F800000, 1'b0);
    send_op(32'h3F800000, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_out_data",  out_data,           32'd0);
    chk("mid_rst_busy",      {31'd0, busy},      32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      if (out_valid) seen++;
      @(posedge clk);
      #1;
    end
    chk("no_out_after_reset", seen, 32'd0);
    run_vec(mk("post_reset", 1, 32'h40000000, 32'h0, 32'h0, 32'h40000000));

    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
